// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder:
// funct3 access codes, FSM state type and access-legality helpers.
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  // Size is encoded in funct3[1:0] for every legal load and store.
  function automatic logic is_misaligned(input logic [2:0] typ, input logic [1:0] addr_lo);
    case (typ[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal(input logic we, input logic [2:0] typ);
    if (we) return !(typ inside {F3_SB, F3_SH, F3_SW});
    return !(typ inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and
// load extraction with sign or zero extension from the addressed lane.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  type_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] sh;
  assign sh = rword_i >> {addr_lo_i, 3'b000};

  // Store data is replicated across lanes so the enables alone pick the target.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = '0;
    rdata_o = '0;
    case (type_i)
      F3_LB: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sh[7]}}, sh[7:0]};
      end
      F3_LH: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sh[15]}}, sh[15:0]};
      end
      F3_LW: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
      F3_LBU:  rdata_o = {24'h0, sh[7:0]};
      F3_LHU:  rdata_o = {16'h0, sh[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: valid/ready request, programmable wait,
// byte/half/word access with extension, valid/ready response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int LATENCY    = 2
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q;
  logic        we_q;
  logic [2:0]  type_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        latch, do_acc;

  logic [31:0] mem [WORDS];

  // With LATENCY=0 the access happens on the accept edge, straight from the request.
  logic                  acc_we;
  logic [2:0]            acc_type;
  logic [31:0]           acc_addr, acc_wdata;
  logic                  acc_err;
  logic [ADDR_WIDTH-3:0] widx;
  logic [3:0]            be;
  logic [31:0]           wdata_al, rdata_al;

  assign acc_we    = (state_q == IDLE) ? req_we    : we_q;
  assign acc_type  = (state_q == IDLE) ? req_type  : type_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign acc_err   = is_illegal(acc_we, acc_type) || is_misaligned(acc_type, acc_addr[1:0]) ||
                     ((acc_addr >> ADDR_WIDTH) != 32'h0);
  assign widx      = acc_addr[ADDR_WIDTH-1:2];

  dmem_lane_align u_align (
    .type_i    (acc_type),
    .addr_lo_i (acc_addr[1:0]),
    .wdata_i   (acc_wdata),
    .rword_i   (mem[widx]),
    .be_o      (be),
    .wdata_o   (wdata_al),
    .rdata_o   (rdata_al)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    do_acc  = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid && ready_q) begin
        latch = 1'b1;
        cnt_d = 4'(LATENCY);
        if (LATENCY == 0) begin
          do_acc  = 1'b1;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          do_acc  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (do_acc) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_we) ? 32'h0 : rdata_al;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      type_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == IDLE);
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (latch) begin
        we_q    <= req_we;
        type_q  <= req_type;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Array is deliberately not reset; do_acc is already low while rst is asserted.
  always_ff @(posedge CLK) begin
    if (do_acc && acc_we && !acc_err)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wdata_al[8*b +: 8];
  end

  assign req_ready = ready_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 and LATENCY=0 instances,
// byte-level reference model, per-cycle response compare, literal anchors.
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = '0, req_ready, req_we = '0, rsp_valid, rsp_ready = '0, rsp_err;
  logic [2:0]  req_type [2];
  logic [31:0] req_addr [2], req_wdata [2], rsp_rdata [2];

  int n_chk = 0, n_fail = 0;

  logic [1:0]  exp_valid = '0;
  logic [31:0] exp_rdata [2];
  logic        exp_err [2];
  bit   [7:0]  bmem [int];

  always #5 CLK = ~CLK;

  dmem_responder #(.ADDR_WIDTH(17), .LATENCY(2)) u0 (
    .CLK(CLK), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_type(req_type[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  dmem_responder #(.ADDR_WIDTH(17), .LATENCY(0)) u1 (
    .CLK(CLK), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_type(req_type[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Spec-level reference: byte-addressed little-endian store, size = 1 << funct3[1:0].
  function automatic void model(input int d, input bit we, input bit [2:0] t, input bit [31:0] a,
                                input bit [31:0] wd, output bit [31:0] rd, output bit err);
    int  sz;
    bit  legal;
    sz    = 1 << t[1:0];
    legal = we ? (t <= 3'd2) : (t == 3'd0 || t == 3'd1 || t == 3'd2 || t == 3'd4 || t == 3'd5);
    err   = !legal || (a % sz != 0) || (a >= 32'h20000);
    rd    = 32'h0;
    if (err) return;
    for (int i = 0; i < sz; i++) begin
      int k;
      k = d * 32'h100000 + int'(a) + i;
      if (we) bmem[k] = 8'(wd >> (8 * i));
      else    rd = rd | (32'(bmem[k]) << (8 * i));
    end
    if (!we && !t[2] && sz < 4 && rd[8*sz-1]) rd = rd | (32'hFFFFFFFF << (8 * sz));
  endfunction

  // Every cycle a response is up it must match the model; otherwise none may appear.
  always @(negedge CLK) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        if (exp_valid[i] && rsp_valid[i]) begin
          chk($sformatf("rsp_rdata[%0d]", i), rsp_rdata[i], exp_rdata[i]);
          chk($sformatf("rsp_err[%0d]", i), 32'(rsp_err[i]), 32'(exp_err[i]));
        end else if (!exp_valid[i]) begin
          chk($sformatf("spurious_rsp[%0d]", i), 32'(rsp_valid[i]), 32'h0);
        end
      end
    end
  end

  // Called and returns at a negedge. hold: extra cycles with rsp_ready=0;
  // pend: present an LBU 0x100 request during the hold to probe backpressure.
  task automatic xact(input int d, input bit we, input bit [2:0] t, input bit [31:0] a, input bit [31:0] wd,
                      input bit [31:0] lit_rd, input bit lit_err, input int hold, input bit pend);
    int n;
    bit [31:0] mrd;
    bit merr;
    logic [31:0] first;
    req_valid[d] = 1'b1; req_we[d] = we; req_type[d] = t; req_addr[d] = a; req_wdata[d] = wd;
    n = 0;
    while (!req_ready[d] && n < 50) begin @(negedge CLK); n++; end
    if (n >= 50) begin chk("accept_timeout", 32'(req_ready[d]), 32'h1); req_valid[d] = 1'b0; return; end
    model(d, we, t, a, wd, mrd, merr);
    chk("model_rdata_vs_literal", mrd, lit_rd);
    chk("model_err_vs_literal", 32'(merr), 32'(lit_err));
    exp_rdata[d] = mrd; exp_err[d] = merr; exp_valid[d] = 1'b1;
    @(negedge CLK);
    req_valid[d] = 1'b0;
    n = 1;
    while (!rsp_valid[d] && n < 40) begin @(negedge CLK); n++; end
    chk("accept_to_rsp_latency", n, (d == 0) ? 3 : 1);
    chk("rsp_rdata_literal", rsp_rdata[d], lit_rd);
    chk("rsp_err_literal", 32'(rsp_err[d]), 32'(lit_err));
    first = rsp_rdata[d];
    if (pend) begin
      req_valid[d] = 1'b1; req_we[d] = 1'b0; req_type[d] = 3'b100; req_addr[d] = 32'h100; req_wdata[d] = 32'h0;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      chk("bp_req_ready_low", 32'(req_ready[d]), 32'h0);
      chk("bp_rsp_valid_held", 32'(rsp_valid[d]), 32'h1);
      chk("bp_rdata_stable", rsp_rdata[d], first);
    end
    rsp_ready[d] = 1'b1;
    @(negedge CLK);
    rsp_ready[d] = 1'b0;
    chk("rsp_valid_cleared", 32'(rsp_valid[d]), 32'h0);
    if (pend) chk("bp_ready_after_handshake", 32'(req_ready[d]), 32'h1);
    exp_valid[d] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_type[i] = '0; req_addr[i] = '0; req_wdata[i] = '0;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("reset_req_ready", 32'(req_ready[0]), 32'h0);
      chk("reset_rsp_valid", 32'(rsp_valid[0]), 32'h0);
      chk("reset_rsp_err", 32'(rsp_err[0]), 32'h0);
      chk("reset_rsp_rdata", rsp_rdata[0], 32'h0);
    end
    rst = 1'b1;
    chk("ready_low_at_release", 32'(req_ready[0]), 32'h0);
    @(negedge CLK);
    chk("ready_after_release", 32'(req_ready[0]), 32'h1);
    chk("ready_after_release_l0", 32'(req_ready[1]), 32'h1);

    xact(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 0);
    xact(0, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0);
    xact(0, 0, 3'b000, 32'h103, 32'h0, 32'hFFFFFFDE, 0, 0, 0);
    xact(0, 0, 3'b100, 32'h103, 32'h0, 32'h000000DE, 0, 0, 0);
    xact(0, 0, 3'b001, 32'h100, 32'h0, 32'hFFFFBEEF, 0, 0, 0);
    xact(0, 0, 3'b101, 32'h102, 32'h0, 32'h0000DEAD, 0, 0, 0);
    xact(0, 1, 3'b000, 32'h101, 32'h12, 32'h0, 0, 0, 0);
    xact(0, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD12EF, 0, 0, 0);
    xact(0, 0, 3'b010, 32'h102, 32'h0, 32'h0, 1, 0, 0);
    xact(0, 1, 3'b001, 32'h101, 32'hABCD, 32'h0, 1, 0, 0);
    xact(0, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD12EF, 0, 0, 0);
    xact(0, 0, 3'b010, 32'h00020000, 32'h0, 32'h0, 1, 0, 0);
    xact(0, 0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 0, 0);
    xact(0, 1, 3'b100, 32'h100, 32'h55, 32'h0, 1, 0, 0);
    xact(0, 1, 3'b001, 32'h102, 32'h7788, 32'h0, 0, 0, 0);
    xact(0, 0, 3'b010, 32'h100, 32'h0, 32'h778812EF, 0, 5, 1);
    xact(0, 0, 3'b100, 32'h100, 32'h0, 32'h000000EF, 0, 0, 0);

    // Store dropped by a reset while it is still waiting.
    xact(0, 1, 3'b010, 32'h200, 32'h55AA55AA, 32'h0, 0, 0, 0);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_type[0] = 3'b010; req_addr[0] = 32'h200; req_wdata[0] = 32'h11111111;
    @(negedge CLK);
    req_valid[0] = 1'b0;
    rst = 1'b0;
    @(negedge CLK);
    chk("midwait_reset_ready", 32'(req_ready[0]), 32'h0);
    chk("midwait_reset_valid", 32'(rsp_valid[0]), 32'h0);
    rst = 1'b1;
    @(negedge CLK);
    xact(0, 0, 3'b010, 32'h200, 32'h0, 32'h55AA55AA, 0, 0, 0);
    xact(0, 0, 3'b101, 32'h100, 32'h0, 32'h000012EF, 0, 0, 0);

    // Zero-latency instance.
    xact(1, 1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 0, 0, 0);
    xact(1, 0, 3'b001, 32'h42, 32'h0, 32'hFFFFCAFE, 0, 0, 0);
    xact(1, 0, 3'b100, 32'h41, 32'h0, 32'h000000F0, 0, 2, 0);
    xact(1, 0, 3'b010, 32'h41, 32'h0, 32'h0, 1, 0, 0);

    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
